// File: rtl/e_sink_ack_arbiter.sv
// Round-robin arbiter that merges N_REQ GrantAck sink-ID requesters into one
// registered E-channel enqueue port, with saturating per-port accept counters.
module e_sink_ack_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SINK_W = 3,
    parameter int CNT_W  = 8,
    localparam int SRC_W = $clog2(N_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          io_in_valid,
    output logic [N_REQ-1:0]          io_in_ready,
    input  logic [N_REQ*SINK_W-1:0]   io_in_bits_sink,
    input  logic                      io_out_ready,
    output logic                      io_out_valid,
    output logic [SINK_W-1:0]         io_out_bits_sink,
    output logic [SRC_W-1:0]          io_out_src,
    output logic [N_REQ*CNT_W-1:0]    io_accept_cnt,
    output logic                      io_idle
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [SRC_W-1:0]    ptr;
    logic [SINK_W-1:0]   out_sink;
    logic [SRC_W-1:0]    out_src;
    logic [CNT_W-1:0]    cnt [N_REQ];
    logic [SINK_W-1:0]   sink_arr [N_REQ];

    logic                can_load;
    logic                fire;
    logic                found;
    logic [SRC_W-1:0]    win;
    logic [SRC_W-1:0]    idx_w;
    logic [SINK_W-1:0]   win_sink;
    int                  idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_port
        assign sink_arr[g]                     = io_in_bits_sink[g*SINK_W +: SINK_W];
        assign io_accept_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Rotating-priority scan starting at ptr; no lock is held between cycles.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        found    = 1'b0;
        win      = '0;
        win_sink = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_w = SRC_W'(idx);
            if (!found && io_in_valid[idx_w]) begin
                found    = 1'b1;
                win      = idx_w;
                win_sink = sink_arr[idx_w];
            end
        end
    end

    always_comb begin
        can_load = (state == EMPTY) || io_out_ready;
        fire     = reset && can_load && found;
        state_d  = state;
        if (state == FULL && io_out_ready) state_d = EMPTY;
        if (fire)                          state_d = FULL;
        io_in_ready = fire ? (N_REQ'(1) << win) : '0;
    end

    // NOTE: the counters are architecturally visible, so they are reset like any other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_sink <= '0;
            out_src  <= '0;
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_d;
            if (fire) begin
                out_sink <= win_sink;
                out_src  <= win;
                ptr      <= (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                for (int i = 0; i < N_REQ; i++) begin
                    if (win == SRC_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign io_out_valid     = (state == FULL);
    assign io_out_bits_sink = out_sink;
    assign io_out_src       = out_src;
    assign io_idle          = (state == EMPTY) && !(|io_in_valid);

endmodule

// File: tb/tb_e_sink_ack_arbiter.sv
// Scoreboard bench for e_sink_ack_arbiter: stimulus pushes hand-computed
// expected outputs, a negedge monitor pops them on every output transfer.
module tb_e_sink_ack_arbiter;

    localparam int N_REQ  = 4;
    localparam int SINK_W = 3;
    localparam int CNT_W  = 2;
    localparam int SRC_W  = 2;

    typedef struct packed {
        logic [SINK_W-1:0] sink;
        logic [SRC_W-1:0]  src;
    } exp_t;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ-1:0]        in_ready;
    logic [N_REQ*SINK_W-1:0] in_sink;
    logic                    out_ready;
    logic                    out_valid;
    logic [SINK_W-1:0]       out_sink;
    logic [SRC_W-1:0]        out_src;
    logic [N_REQ*CNT_W-1:0]  accept_cnt;
    logic                    idle;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    e_sink_ack_arbiter #(.N_REQ(N_REQ), .SINK_W(SINK_W), .CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (in_valid),
        .io_in_ready      (in_ready),
        .io_in_bits_sink  (in_sink),
        .io_out_ready     (out_ready),
        .io_out_valid     (out_valid),
        .io_out_bits_sink (out_sink),
        .io_out_src       (out_src),
        .io_accept_cnt    (accept_cnt),
        .io_idle          (idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_sinks(input logic [SINK_W-1:0] s0, input logic [SINK_W-1:0] s1,
                             input logic [SINK_W-1:0] s2, input logic [SINK_W-1:0] s3);
        in_sink = {s3, s2, s1, s0};
    endtask

    // Expect an accept on port p this cycle; pushes the entry it will produce.
    task automatic expect_accept(input int p, input logic [SINK_W-1:0] s);
        @(negedge clock);
        check("in_ready", in_ready, N_REQ'(1) << p);
        sb_q.push_back('{sink: s, src: SRC_W'(p)});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid & ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'(out_sink), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("out_sink", out_sink, e.sink);
                    check("out_src", out_src, e.src);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset state with all valids high
        reset     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_sinks(1, 2, 3, 4);
        repeat (2) @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 4'b0000);
        check("rst_cnt", accept_cnt, 8'h00);
        check("rst_idle", idle, 0);
        step();
        reset = 1'b1;

        // Test 2: round robin over 8 cycles, port0 first after reset
        expect_accept(0, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            expect_accept(k % 4, SINK_W'((k % 4) + 1));
        end
        step();
        in_valid = 4'b0000;
        @(negedge clock);
        check("rr_cnt", accept_cnt, 8'hAA);
        check("rr_out_valid", out_valid, 1);
        step();
        @(negedge clock);
        check("rr_drain_valid", out_valid, 0);
        check("rr_idle", idle, 1);

        // Test 3: backpressure holds the output and ptr
        step();
        set_sinks(1, 2, 5, 4);
        in_valid = 4'b0100;
        expect_accept(2, 5);
        step();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_sink", out_sink, 5);
            check("bp_src", out_src, 2);
            check("bp_ready", in_ready, 4'b0000);
            check("bp_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        expect_accept(3, 4);
        step();
        in_valid = 4'b0000;
        @(negedge clock);
        check("bp_next_src", out_src, 3);
        step();

        // Test 4: sparse valids alternate between port3 and port1
        do_reset();
        in_valid = 4'b0010;
        expect_accept(1, 2);
        step();
        in_valid = 4'b1010;
        expect_accept(3, 4);
        step();
        expect_accept(1, 2);
        step();
        expect_accept(3, 4);
        step();
        expect_accept(1, 2);
        step();
        in_valid = 4'b0000;
        @(negedge clock);
        check("sparse_cnt", accept_cnt, 8'h8C);
        step();

        // Test 5: saturation of a 2-bit counter
        do_reset();
        in_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            expect_accept(0, 1);
            if (k == 3) check("sat_cnt_at3", accept_cnt, 8'h03);
        end
        step();
        @(negedge clock);
        check("sat_cnt_hold", accept_cnt, 8'h03);
        check("pre_rst_valid", out_valid, 1);

        // Test 6: asynchronous reset between edges drops the pending entry
        #1;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 4'b0000);
        check("async_rst_cnt", accept_cnt, 8'h00);
        step();
        reset = 1'b1;
        in_valid = 4'b1111;
        set_sinks(1, 2, 3, 4);
        expect_accept(0, 1);
        step();
        expect_accept(1, 2);
        step();
        in_valid = 4'b0000;
        repeat (3) step();
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
